// File: rtl/mdu_iter_if.sv
// Request/response bundle between the EX stage and the iterative multiply/divide unit.
// The master side is EX; the slave side is the unit itself.
interface mdu_iter_if #(
  parameter int WIDTH = 32
);
  logic             req_valid;
  logic             req_ready;
  logic [1:0]       req_op;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic             cancel;
  logic             resp_valid;
  logic             resp_ready;
  logic [WIDTH-1:0] resp_hi;
  logic [WIDTH-1:0] resp_lo;
  logic             busy;

  modport master (
    output req_valid, req_op, req_a, req_b, cancel, resp_ready,
    input  req_ready, resp_valid, resp_hi, resp_lo, busy
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, cancel, resp_ready,
    output req_ready, resp_valid, resp_hi, resp_lo, busy
  );
endinterface

// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit: shift-add multiply (radix 2^MUL_STEP), restoring
// radix-2 divide, sign fix-up in a final cycle, and a held HI/LO response.
module mdu_iter #(
  parameter int WIDTH    = 32,
  parameter int MUL_STEP = 1
) (
  input  logic      clk,
  input  logic      resetn,
  mdu_iter_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;
  localparam logic [CW-1:0] N_MUL = CW'(WIDTH / MUL_STEP);
  localparam logic [CW-1:0] N_DIV = CW'(WIDTH);

  logic [1:0]         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               is_div_q, is_div_d;
  logic               sign_q, sign_d;
  logic               rsign_q, rsign_d;
  logic               bzero_q, bzero_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  logic             accept;
  logic             a_sgn, b_sgn;
  logic [WIDTH-1:0] mag_a, mag_b;

  assign accept = bus.req_valid & bus.req_ready;
  assign a_sgn  = ~bus.req_op[0] & bus.req_a[WIDTH-1];
  assign b_sgn  = ~bus.req_op[0] & bus.req_b[WIDTH-1];
  assign mag_a  = a_sgn ? -bus.req_a : bus.req_a;
  assign mag_b  = b_sgn ? -bus.req_b : bus.req_b;

  // Multiply step: one shifted copy of the multiplicand per retired multiplier bit.
  logic [WIDTH+MUL_STEP-1:0]   pp_term [MUL_STEP];
  logic [WIDTH+MUL_STEP-1:0]   pp_sum;
  logic [WIDTH+MUL_STEP-1:0]   mul_sum;
  logic [2*WIDTH+MUL_STEP-1:0] mul_wide;
  logic [2*WIDTH-1:0]          mul_next;

  for (genvar gi = 0; gi < MUL_STEP; gi++) begin : g_pp
    assign pp_term[gi] = acc_q[gi] ? ({{MUL_STEP{1'b0}}, opnd_q} << gi) : '0;
  end

  always_comb begin
    pp_sum = '0;
    for (int i = 0; i < MUL_STEP; i++) begin
      pp_sum = pp_sum + pp_term[i];
    end
  end

  assign mul_sum  = {{MUL_STEP{1'b0}}, acc_q[2*WIDTH-1:WIDTH]} + pp_sum;
  assign mul_wide = {mul_sum, acc_q[WIDTH-1:0]};
  assign mul_next = mul_wide[2*WIDTH+MUL_STEP-1:MUL_STEP];

  // Divide step: acc holds {remainder, quotient}; the trial subtract needs one extra bit.
  logic [WIDTH:0]     rem_shift, diff;
  logic [WIDTH-1:0]   rem_new;
  logic [2*WIDTH-1:0] div_next;

  assign rem_shift = acc_q[2*WIDTH-1:WIDTH-1];
  assign diff      = rem_shift - {1'b0, opnd_q};
  assign rem_new   = diff[WIDTH] ? rem_shift[WIDTH-1:0] : diff[WIDTH-1:0];
  assign div_next  = {rem_new, acc_q[WIDTH-2:0], ~diff[WIDTH]};

  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  assign prod_fix = sign_q  ? -acc_q : acc_q;
  assign quo_fix  = sign_q  ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem_fix  = rsign_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    sign_d   = sign_q;
    rsign_d  = rsign_q;
    bzero_d  = bzero_q;
    a_d      = a_q;
    opnd_d   = opnd_q;
    acc_d    = acc_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    if (bus.cancel && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            state_d  = S_CALC;
            is_div_d = bus.req_op[1];
            sign_d   = a_sgn ^ b_sgn;
            rsign_d  = a_sgn;
            bzero_d  = (bus.req_b == '0);
            a_d      = bus.req_a;
            cnt_d    = bus.req_op[1] ? N_DIV : N_MUL;
            opnd_d   = bus.req_op[1] ? mag_b : mag_a;
            acc_d    = {{WIDTH{1'b0}}, (bus.req_op[1] ? mag_a : mag_b)};
          end
        end
        S_CALC: begin
          cnt_d = cnt_q - CW'(1);
          acc_d = is_div_q ? div_next : mul_next;
          if (cnt_q == CW'(1)) state_d = S_FIX;
        end
        S_FIX: begin
          state_d = S_DONE;
          if (!is_div_q) begin
            {hi_d, lo_d} = prod_fix;
          end else if (bzero_q) begin
            hi_d = a_q;
            lo_d = '1;
          end else begin
            hi_d = rem_fix;
            lo_d = quo_fix;
          end
        end
        S_DONE: begin
          if (bus.resp_ready) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      sign_q   <= 1'b0;
      rsign_q  <= 1'b0;
      bzero_q  <= 1'b0;
      a_q      <= '0;
      opnd_q   <= '0;
      acc_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      sign_q   <= sign_d;
      rsign_q  <= rsign_d;
      bzero_q  <= bzero_d;
      a_q      <= a_d;
      opnd_q   <= opnd_d;
      acc_q    <= acc_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign bus.req_ready  = (state_q == S_IDLE) & ~bus.cancel;
  assign bus.resp_valid = (state_q == S_DONE);
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.resp_hi    = hi_q;
  assign bus.resp_lo    = lo_q;
endmodule

// File: tb/tb_mdu_iter.sv
// Directed bench for mdu_iter: one instance at MUL_STEP=1 for the full sequence,
// a second at MUL_STEP=4 for the radix-16 latency/result check.
module tb_mdu_iter;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   n_pass = 0;
  int   n_total = 0;
  int   lat;
  int   seen;

  always #5 clk = ~clk;

  mdu_iter_if #(.WIDTH(32)) bus1 ();
  mdu_iter_if #(.WIDTH(32)) bus4 ();

  mdu_iter #(.WIDTH(32), .MUL_STEP(1)) dut1 (.clk(clk), .resetn(resetn), .bus(bus1));
  mdu_iter #(.WIDTH(32), .MUL_STEP(4)) dut4 (.clk(clk), .resetn(resetn), .bus(bus4));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic start_op(input string tag, input logic [1:0] op,
                          input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    chk({tag, " req_ready"}, 64'(bus1.req_ready), 64'd1);
    bus1.req_valid = 1'b1;
    bus1.req_op    = op;
    bus1.req_a     = a;
    bus1.req_b     = b;
    @(posedge clk);
    #1;
    bus1.req_valid = 1'b0;
    bus1.req_op    = ~op;
    bus1.req_a     = 32'hDEAD_BEEF;
    bus1.req_b     = 32'h1234_5678;
  endtask

  task automatic wait_resp(input string tag, input int exp_lat,
                           input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    lat = 0;
    while (lat < 100) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (bus1.resp_valid) break;
    end
    chk({tag, " latency"}, 64'(lat), 64'(exp_lat));
    chk({tag, " hi"}, 64'(bus1.resp_hi), 64'(exp_hi));
    chk({tag, " lo"}, 64'(bus1.resp_lo), 64'(exp_lo));
    $display("op %s: hi=%h lo=%h latency=%0d", tag, bus1.resp_hi, bus1.resp_lo, lat);
    if (bus1.resp_ready) begin
      @(posedge clk);
      @(negedge clk);
      chk({tag, " idle after handshake"}, 64'({bus1.busy, bus1.resp_valid}), 64'd0);
    end
  endtask

  initial begin
    bus1.req_valid = 1'b0; bus1.req_op = 2'b00; bus1.req_a = '0; bus1.req_b = '0;
    bus1.cancel = 1'b0; bus1.resp_ready = 1'b1;
    bus4.req_valid = 1'b0; bus4.req_op = 2'b00; bus4.req_a = '0; bus4.req_b = '0;
    bus4.cancel = 1'b0; bus4.resp_ready = 1'b1;

    #12;
    chk("reset busy", 64'(bus1.busy), 64'd0);
    chk("reset resp_valid", 64'(bus1.resp_valid), 64'd0);
    chk("reset hi/lo", {bus1.resp_hi, bus1.resp_lo}, 64'd0);
    chk("reset req_ready", 64'(bus1.req_ready), 64'd1);
    @(negedge clk);
    resetn = 1'b1;

    start_op("multu max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_resp("multu max", 33, 32'hFFFF_FFFE, 32'h0000_0001);

    @(negedge clk);
    bus4.req_valid = 1'b1; bus4.req_op = 2'b01;
    bus4.req_a = 32'hFFFF_FFFF; bus4.req_b = 32'hFFFF_FFFF;
    @(posedge clk);
    #1;
    bus4.req_valid = 1'b0; bus4.req_a = '0; bus4.req_b = '0;
    lat = 0;
    while (lat < 100) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (bus4.resp_valid) break;
    end
    chk("multu step4 latency", 64'(lat), 64'd9);
    chk("multu step4 hi/lo", {bus4.resp_hi, bus4.resp_lo}, 64'hFFFF_FFFE_0000_0001);
    $display("op multu step4: hi=%h lo=%h latency=%0d", bus4.resp_hi, bus4.resp_lo, lat);

    start_op("mult -7*3", 2'b00, 32'hFFFF_FFF9, 32'd3);
    wait_resp("mult -7*3", 33, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    start_op("div -7/2", 2'b10, 32'hFFFF_FFF9, 32'd2);
    wait_resp("div -7/2", 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    start_op("div ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_resp("div ovf", 33, 32'h0000_0000, 32'h8000_0000);
    start_op("divu 100/0", 2'b11, 32'd100, 32'd0);
    wait_resp("divu 100/0", 33, 32'd100, 32'hFFFF_FFFF);
    start_op("div -5/0", 2'b10, 32'hFFFF_FFFB, 32'd0);
    wait_resp("div -5/0", 33, 32'hFFFF_FFFB, 32'hFFFF_FFFF);

    // Backpressure: result must hold while the consumer stalls.
    bus1.resp_ready = 1'b0;
    start_op("divu 20/3", 2'b11, 32'd20, 32'd3);
    wait_resp("divu 20/3", 33, 32'd2, 32'd6);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall outputs", {bus1.resp_hi, bus1.resp_lo}, {32'd2, 32'd6});
      chk("stall flags", 64'({bus1.resp_valid, bus1.req_ready}), 64'b10);
    end
    bus1.resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("release idle", 64'({bus1.busy, bus1.req_ready}), 64'b01);
    bus1.req_valid = 1'b1; bus1.req_op = 2'b11; bus1.req_a = 32'd9; bus1.req_b = 32'd4;
    @(posedge clk);
    #1;
    bus1.req_valid = 1'b0;
    chk("accept after release", 64'(bus1.busy), 64'd1);
    wait_resp("divu 9/4", 33, 32'd1, 32'd2);

    // Cancel sampled at the tenth CALC edge.
    start_op("divu cancel", 2'b11, 32'd1000, 32'd7);
    repeat (9) @(posedge clk);
    @(negedge clk);
    bus1.cancel = 1'b1;
    chk("cancel blocks ready", 64'({bus1.busy, bus1.req_ready}), 64'b10);
    @(negedge clk);
    chk("cancel busy drop", 64'({bus1.busy, bus1.resp_valid}), 64'd0);
    bus1.cancel = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus1.resp_valid) seen++;
    end
    chk("cancel no response", 64'(seen), 64'd0);
    $display("op divu cancel: responses after cancel=%0d", seen);
    start_op("divu 7/2", 2'b11, 32'd7, 32'd2);
    wait_resp("divu 7/2", 33, 32'd1, 32'd3);

    // Asynchronous reset in the middle of a cycle.
    start_op("mult reset", 2'b00, 32'd9, 32'd9);
    repeat (5) @(posedge clk);
    #2;
    resetn = 1'b0;
    #1;
    chk("async reset flags", 64'({bus1.busy, bus1.resp_valid}), 64'd0);
    chk("async reset hi/lo", {bus1.resp_hi, bus1.resp_lo}, 64'd0);
    $display("op async reset: busy=%0b hi=%h lo=%h", bus1.busy, bus1.resp_hi, bus1.resp_lo);
    @(negedge clk);
    resetn = 1'b1;
    start_op("mult 5*6", 2'b00, 32'd5, 32'd6);
    wait_resp("mult 5*6", 33, 32'd0, 32'd30);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
